light_sequencer: RTL and testbench

LIGHT_SEQUENCER -- requirements
Module: light_sequencer

---
 rtl/light_sequencer_pkg.sv | 32 +++
 rtl/light_sequencer_countdown.sv | 34 +++
 rtl/light_sequencer.sv | 155 +++++++++++++++
 tb/tb_light_sequencer.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/light_sequencer_pkg.sv
// Shared types, default durations and lane helpers for the light sequencer.
package light_sequencer_pkg;

   localparam int unsigned TIMER_W         = 7;
   localparam int unsigned NUM_LANES       = 8;
   localparam int unsigned DEF_GREEN_TIME  = 30;
   localparam int unsigned DEF_YELLOW_TIME = 3;
   localparam int unsigned DEF_ALLRED_TIME = 1;

   typedef enum logic [1:0] {
      GREEN    = 2'd0,
      YELLOW   = 2'd1,
      ALL_RED  = 2'd2,
      EM_GREEN = 2'd3
   } state_e;

   // Lane 0 is the leftmost (MSB) bit of every lane vector.
   typedef logic [0:NUM_LANES-1] lane_t;

   function automatic lane_t phase_lanes(input logic [1:0] phase);
      lane_t m;
      m = '0;
      m[{phase, 1'b0}] = 1'b1;
      m[{phase, 1'b1}] = 1'b1;
      return m;
   endfunction

   function automatic logic [TIMER_W-1:0] clamp_time(input logic [TIMER_W-1:0] t);
      return (t == '0) ? TIMER_W'(1) : t;
   endfunction

endpackage

// File: rtl/light_sequencer_countdown.sv
// tick_countdown: loadable 7-bit down-counter; expires on a tick while at 1.
module tick_countdown
   import light_sequencer_pkg::*;
#(
   parameter logic [TIMER_W-1:0] RESET_VAL = TIMER_W'(DEF_ALLRED_TIME)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               tick_i,
   input  logic               load_i,
   input  logic [TIMER_W-1:0] load_val_i,
   output logic               expire_o
);

   logic [TIMER_W-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (load_i) begin
         count_d = load_val_i;
      end else if (tick_i && (count_q > TIMER_W'(1))) begin
         count_d = count_q - TIMER_W'(1);
      end
   end

   // NOTE: sequential state is updated with non-blocking assignments only.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) count_q <= RESET_VAL;
      else     count_q <= count_d;
   end

   assign expire_o = tick_i && (count_q <= TIMER_W'(1));

endmodule

// File: rtl/light_sequencer.sv
// Four-phase traffic light sequencer with emergency preemption; all outputs registered.
module light_sequencer
   import light_sequencer_pkg::*;
#(
   parameter int unsigned GREEN_TIME  = DEF_GREEN_TIME,
   parameter int unsigned YELLOW_TIME = DEF_YELLOW_TIME,
   parameter int unsigned ALLRED_TIME = DEF_ALLRED_TIME
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         tick,
   input  logic         loadCommand,
   input  logic [6:0]   loadTime,
   input  logic [0:7]   laneOutput,
   output logic [0:7]   lightGreen,
   output logic [0:7]   lightYellow,
   output logic [0:7]   lightRed,
   output logic         emergencyActive,
   output logic         emergencyDone
);

   state_e             state_q, state_d;
   logic [1:0]         phase_q, phase_d;
   logic               pend_q, pend_d;
   lane_t              pmask_q, pmask_d;
   logic [TIMER_W-1:0] ptime_q, ptime_d;
   lane_t              emask_q, emask_d;
   logic               emclr_q, emclr_d;
   lane_t              green_d, yellow_d;
   logic               done_d, active_d;
   logic               req, expire, load;
   logic [TIMER_W-1:0] load_val;

   tick_countdown #(
      .RESET_VAL (TIMER_W'(ALLRED_TIME))
   ) u_timer (
      .clk        (clk),
      .rst        (reset),
      .tick_i     (tick),
      .load_i     (load),
      .load_val_i (load_val),
      .expire_o   (expire)
   );

   assign req = loadCommand && (laneOutput != '0);

   // NOTE: every output of this block gets a default first, so no latches are inferred.
   always_comb begin
      state_d  = state_q;
      phase_d  = phase_q;
      pend_d   = pend_q;
      pmask_d  = pmask_q;
      ptime_d  = ptime_q;
      emask_d  = emask_q;
      emclr_d  = emclr_q;
      done_d   = 1'b0;
      load     = 1'b0;
      load_val = '0;

      if (req && (state_q != EM_GREEN)) begin
         pend_d  = 1'b1;
         pmask_d = laneOutput;
         ptime_d = loadTime;
      end

      // emclr_q marks the yellow/all-red that clears an emergency green.
      unique case (state_q)
         GREEN: begin
            if (pend_d || expire) begin
               state_d  = YELLOW;
               load     = 1'b1;
               load_val = TIMER_W'(YELLOW_TIME);
            end
         end
         YELLOW: begin
            if (expire) begin
               state_d  = ALL_RED;
               load     = 1'b1;
               load_val = TIMER_W'(ALLRED_TIME);
               if (!emclr_q) phase_d = phase_q + 2'd1;
            end
         end
         ALL_RED: begin
            if (expire) begin
               load    = 1'b1;
               emclr_d = 1'b0;
               if (pend_d) begin
                  state_d  = EM_GREEN;
                  load_val = clamp_time(ptime_d);
                  emask_d  = pmask_d;
                  pend_d   = 1'b0;
               end else begin
                  state_d  = GREEN;
                  load_val = TIMER_W'(GREEN_TIME);
               end
            end
         end
         EM_GREEN: begin
            if (req) begin
               load     = 1'b1;
               load_val = clamp_time(loadTime);
               emask_d  = laneOutput;
            end else if (expire) begin
               state_d  = YELLOW;
               load     = 1'b1;
               load_val = TIMER_W'(YELLOW_TIME);
               emclr_d  = 1'b1;
               done_d   = 1'b1;
            end
         end
         default: state_d = ALL_RED;
      endcase

      green_d  = '0;
      yellow_d = '0;
      unique case (state_d)
         GREEN:    green_d  = phase_lanes(phase_d);
         EM_GREEN: green_d  = emask_d;
         YELLOW:   yellow_d = emclr_d ? emask_d : phase_lanes(phase_d);
         default:  ;
      endcase
      active_d = pend_d || (state_d == EM_GREEN);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q         <= ALL_RED;
         phase_q         <= 2'd0;
         pend_q          <= 1'b0;
         pmask_q         <= '0;
         ptime_q         <= '0;
         emask_q         <= '0;
         emclr_q         <= 1'b0;
         lightGreen      <= '0;
         lightYellow     <= '0;
         lightRed        <= '1;
         emergencyActive <= 1'b0;
         emergencyDone   <= 1'b0;
      end else begin
         state_q         <= state_d;
         phase_q         <= phase_d;
         pend_q          <= pend_d;
         pmask_q         <= pmask_d;
         ptime_q         <= ptime_d;
         emask_q         <= emask_d;
         emclr_q         <= emclr_d;
         lightGreen      <= green_d;
         lightYellow     <= yellow_d;
         lightRed        <= ~(green_d | yellow_d);
         emergencyActive <= active_d;
         emergencyDone   <= done_d;
      end
   end

endmodule

// File: tb/tb_light_sequencer.sv
// Directed self-checking bench for light_sequencer with default durations 30/3/1.
module tb_light_sequencer;

   logic       clk = 1'b0;
   logic       reset;
   logic       tick;
   logic       loadCommand;
   logic [6:0] loadTime;
   logic [0:7] laneOutput;
   logic [0:7] lightGreen, lightYellow, lightRed;
   logic       emergencyActive, emergencyDone;

   int checks   = 0;
   int errors   = 0;
   int done_cnt = 0;

   light_sequencer dut (
      .clk             (clk),
      .reset           (reset),
      .tick            (tick),
      .loadCommand     (loadCommand),
      .loadTime        (loadTime),
      .laneOutput      (laneOutput),
      .lightGreen      (lightGreen),
      .lightYellow     (lightYellow),
      .lightRed        (lightRed),
      .emergencyActive (emergencyActive),
      .emergencyDone   (emergencyDone)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (emergencyDone === 1'b1) done_cnt++;

   task automatic step(input logic t, input logic lc, input logic [6:0] lt, input logic [0:7] lo);
      tick = t; loadCommand = lc; loadTime = lt; laneOutput = lo;
      @(posedge clk); #1;
      tick = 1'b0; loadCommand = 1'b0; loadTime = '0; laneOutput = '0;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) step(1'b1, 1'b0, 7'd0, 8'h00);
   endtask

   task automatic test_reset;
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({lightGreen, lightYellow, lightRed} !== {8'h00, 8'h00, 8'hFF}) begin
         errors++;
         $display("FAIL reset_lights g=%b y=%b r=%b want g=00000000 y=00000000 r=11111111", lightGreen, lightYellow, lightRed);
      end
      checks++;
      if ({emergencyActive, emergencyDone} !== 2'b00) begin
         errors++;
         $display("FAIL reset_flags active=%b done=%b want 0 0", emergencyActive, emergencyDone);
      end
      reset = 1'b0;
      step(1'b0, 1'b0, 7'd0, 8'h00);
      step(1'b0, 1'b0, 7'd0, 8'h00);
      checks++;
      if ({lightGreen, lightYellow, lightRed} !== {8'h00, 8'h00, 8'hFF}) begin
         errors++;
         $display("FAIL reset_hold g=%b y=%b r=%b want all red", lightGreen, lightYellow, lightRed);
      end
   endtask

   task automatic test_normal_cycle;
      logic [0:7] want;
      ticks(1);
      checks++;
      if ({lightGreen, lightYellow, lightRed} !== {8'hC0, 8'h00, 8'h3F}) begin
         errors++;
         $display("FAIL first_green g=%b y=%b r=%b want g=11000000", lightGreen, lightYellow, lightRed);
      end
      ticks(29);
      repeat (3) step(1'b0, 1'b0, 7'd0, 8'h00);
      checks++;
      if ({lightGreen, lightYellow, lightRed} !== {8'hC0, 8'h00, 8'h3F}) begin
         errors++;
         $display("FAIL green_29_ticks g=%b y=%b r=%b want g=11000000", lightGreen, lightYellow, lightRed);
      end
      ticks(1);
      checks++;
      if ({lightGreen, lightYellow, lightRed} !== {8'h00, 8'hC0, 8'h3F}) begin
         errors++;
         $display("FAIL yellow_entry g=%b y=%b r=%b want y=11000000", lightGreen, lightYellow, lightRed);
      end
      ticks(2);
      checks++;
      if ({lightGreen, lightYellow, lightRed} !== {8'h00, 8'hC0, 8'h3F}) begin
         errors++;
         $display("FAIL yellow_2_ticks g=%b y=%b r=%b want y=11000000", lightGreen, lightYellow, lightRed);
      end
      ticks(1);
      checks++;
      if ({lightGreen, lightYellow, lightRed} !== {8'h00, 8'h00, 8'hFF}) begin
         errors++;
         $display("FAIL allred g=%b y=%b r=%b want all red", lightGreen, lightYellow, lightRed);
      end
      ticks(1);
      checks++;
      if ({lightGreen, lightYellow, lightRed} !== {8'h30, 8'h00, 8'hCF}) begin
         errors++;
         $display("FAIL phase1_green g=%b y=%b r=%b want g=00110000", lightGreen, lightYellow, lightRed);
      end
      for (int p = 0; p < 3; p++) begin
         ticks(34);
         want = (p == 0) ? 8'h0C : (p == 1) ? 8'h03 : 8'hC0;
         checks++;
         if ({lightGreen, lightYellow, lightRed} !== {want, 8'h00, ~want}) begin
            errors++;
            $display("FAIL phase_walk%0d g=%b y=%b r=%b want g=%b", p, lightGreen, lightYellow, lightRed, want);
         end
      end
   endtask

   task automatic test_emergency;
      int d0;
      d0 = done_cnt;
      step(1'b0, 1'b1, 7'd5, 8'b0000_1100);
      checks++;
      if ({lightGreen, lightYellow, lightRed, emergencyActive} !== {8'h00, 8'hC0, 8'h3F, 1'b1}) begin
         errors++;
         $display("FAIL preempt_yellow g=%b y=%b r=%b act=%b want y=11000000 act=1", lightGreen, lightYellow, lightRed, emergencyActive);
      end
      ticks(3);
      checks++;
      if ({lightGreen, lightYellow, lightRed, emergencyActive} !== {8'h00, 8'h00, 8'hFF, 1'b1}) begin
         errors++;
         $display("FAIL preempt_allred g=%b y=%b r=%b act=%b want all red act=1", lightGreen, lightYellow, lightRed, emergencyActive);
      end
      ticks(1);
      checks++;
      if ({lightGreen, lightYellow, lightRed, emergencyDone} !== {8'h0C, 8'h00, 8'hF3, 1'b0}) begin
         errors++;
         $display("FAIL em_green g=%b y=%b r=%b done=%b want g=00001100 done=0", lightGreen, lightYellow, lightRed, emergencyDone);
      end
      ticks(4);
      checks++;
      if ({lightGreen, lightYellow, lightRed} !== {8'h0C, 8'h00, 8'hF3}) begin
         errors++;
         $display("FAIL em_green_4 g=%b y=%b r=%b want g=00001100", lightGreen, lightYellow, lightRed);
      end
      ticks(1);
      checks++;
      if ({lightGreen, lightYellow, lightRed, emergencyDone} !== {8'h00, 8'h0C, 8'hF3, 1'b1}) begin
         errors++;
         $display("FAIL em_exit g=%b y=%b r=%b done=%b want y=00001100 done=1", lightGreen, lightYellow, lightRed, emergencyDone);
      end
      step(1'b0, 1'b0, 7'd0, 8'h00);
      checks++;
      if ({emergencyDone, emergencyActive} !== 2'b00) begin
         errors++;
         $display("FAIL em_after_done done=%b act=%b want 0 0", emergencyDone, emergencyActive);
      end
      ticks(4);
      checks++;
      if ({lightGreen, lightYellow, lightRed} !== {8'h30, 8'h00, 8'hCF}) begin
         errors++;
         $display("FAIL em_resume g=%b y=%b r=%b want g=00110000", lightGreen, lightYellow, lightRed);
      end
      checks++;
      if (done_cnt - d0 !== 1) begin
         errors++;
         $display("FAIL em_done_count got %0d want 1", done_cnt - d0);
      end
   endtask

   task automatic test_ignore_zero_mask;
      step(1'b0, 1'b1, 7'd9, 8'h00);
      step(1'b0, 1'b0, 7'd0, 8'h00);
      checks++;
      if ({lightGreen, lightYellow, lightRed, emergencyActive} !== {8'h30, 8'h00, 8'hCF, 1'b0}) begin
         errors++;
         $display("FAIL zero_mask g=%b y=%b r=%b act=%b want g=00110000 act=0", lightGreen, lightYellow, lightRed, emergencyActive);
      end
   endtask

   task automatic test_zero_time;
      int d0;
      d0 = done_cnt;
      step(1'b0, 1'b1, 7'd0, 8'b1000_0000);
      ticks(4);
      repeat (3) step(1'b0, 1'b0, 7'd0, 8'h00);
      checks++;
      if ({lightGreen, lightYellow, lightRed} !== {8'h80, 8'h00, 8'h7F}) begin
         errors++;
         $display("FAIL zt_em_green g=%b y=%b r=%b want g=10000000", lightGreen, lightYellow, lightRed);
      end
      ticks(1);
      checks++;
      if ({lightGreen, lightYellow, lightRed, emergencyDone} !== {8'h00, 8'h80, 8'h7F, 1'b1}) begin
         errors++;
         $display("FAIL zt_one_tick g=%b y=%b r=%b done=%b want y=10000000 done=1", lightGreen, lightYellow, lightRed, emergencyDone);
      end
      ticks(4);
      checks++;
      if ({lightGreen, lightYellow, lightRed, done_cnt - d0} !== {8'h0C, 8'h00, 8'hF3, 32'd1}) begin
         errors++;
         $display("FAIL zt_resume g=%b y=%b r=%b dones=%0d want g=00001100 dones=1", lightGreen, lightYellow, lightRed, done_cnt - d0);
      end
   endtask

   task automatic test_replace;
      int d0;
      d0 = done_cnt;
      step(1'b0, 1'b1, 7'd5, 8'b0011_0000);
      ticks(4);
      checks++;
      if ({lightGreen, lightYellow, lightRed} !== {8'h30, 8'h00, 8'hCF}) begin
         errors++;
         $display("FAIL rp_first_green g=%b y=%b r=%b want g=00110000", lightGreen, lightYellow, lightRed);
      end
      ticks(2);
      step(1'b0, 1'b1, 7'd5, 8'b0000_0011);
      checks++;
      if ({lightGreen, lightYellow, lightRed, emergencyDone, emergencyActive} !== {8'h03, 8'h00, 8'hFC, 1'b0, 1'b1}) begin
         errors++;
         $display("FAIL rp_switch g=%b y=%b r=%b done=%b act=%b want g=00000011 done=0 act=1", lightGreen, lightYellow, lightRed, emergencyDone, emergencyActive);
      end
      ticks(4);
      checks++;
      if ({lightGreen, lightYellow, lightRed} !== {8'h03, 8'h00, 8'hFC}) begin
         errors++;
         $display("FAIL rp_reload g=%b y=%b r=%b want g=00000011", lightGreen, lightYellow, lightRed);
      end
      ticks(1);
      checks++;
      if ({lightGreen, lightYellow, lightRed} !== {8'h00, 8'h03, 8'hFC}) begin
         errors++;
         $display("FAIL rp_exit g=%b y=%b r=%b want y=00000011", lightGreen, lightYellow, lightRed);
      end
      ticks(4);
      checks++;
      if ({lightGreen, lightYellow, lightRed, done_cnt - d0} !== {8'h03, 8'h00, 8'hFC, 32'd1}) begin
         errors++;
         $display("FAIL rp_resume g=%b y=%b r=%b dones=%0d want g=00000011 dones=1", lightGreen, lightYellow, lightRed, done_cnt - d0);
      end
   endtask

   task automatic test_tick_and_load;
      ticks(30);
      step(1'b1, 1'b1, 7'd2, 8'b0011_1100);
      ticks(1);
      checks++;
      if ({lightGreen, lightYellow, lightRed, emergencyActive} !== {8'h00, 8'h03, 8'hFC, 1'b1}) begin
         errors++;
         $display("FAIL tl_yellow g=%b y=%b r=%b act=%b want y=00000011 act=1", lightGreen, lightYellow, lightRed, emergencyActive);
      end
      ticks(1);
      checks++;
      if ({lightGreen, lightYellow, lightRed} !== {8'h00, 8'h00, 8'hFF}) begin
         errors++;
         $display("FAIL tl_allred g=%b y=%b r=%b want all red", lightGreen, lightYellow, lightRed);
      end
      ticks(1);
      checks++;
      if ({lightGreen, lightYellow, lightRed} !== {8'h3C, 8'h00, 8'hC3}) begin
         errors++;
         $display("FAIL tl_em_green g=%b y=%b r=%b want g=00111100", lightGreen, lightYellow, lightRed);
      end
   endtask

   task automatic test_reset_mid_em;
      int d0;
      d0 = done_cnt;
      ticks(1);
      #1 reset = 1'b1;
      #1;
      checks++;
      if ({lightGreen, lightYellow, lightRed, emergencyActive, emergencyDone} !== {8'h00, 8'h00, 8'hFF, 2'b00}) begin
         errors++;
         $display("FAIL rst_mid_em g=%b y=%b r=%b act=%b done=%b want all red 0 0", lightGreen, lightYellow, lightRed, emergencyActive, emergencyDone);
      end
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      step(1'b0, 1'b0, 7'd0, 8'h00);
      ticks(1);
      checks++;
      if ({lightGreen, lightYellow, lightRed, emergencyActive} !== {8'hC0, 8'h00, 8'h3F, 1'b0}) begin
         errors++;
         $display("FAIL rst_discard g=%b y=%b r=%b act=%b want g=11000000 act=0", lightGreen, lightYellow, lightRed, emergencyActive);
      end
      checks++;
      if (done_cnt != d0) begin
         errors++;
         $display("FAIL rst_no_done got %0d pulses want 0", done_cnt - d0);
      end
   endtask

   initial begin
      reset = 1'b1; tick = 1'b0; loadCommand = 1'b0; loadTime = '0; laneOutput = '0;
      test_reset();
      test_normal_cycle();
      test_emergency();
      test_ignore_zero_mask();
      test_zero_time();
      test_replace();
      test_tick_and_load();
      test_reset_mid_em();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
